// File: rtl/fifo4_ctrl_if.sv
// Handshake/status bundle between a FIFO client and the fifo4_ctrl storage/pointer block.
// The slave side is the FIFO controller; the master side is the requester and mux consumer.
interface fifo4_ctrl_if #(
  parameter int unsigned DW = 16
);
  logic          push;
  logic          pop;
  logic [DW-1:0] din;
  logic [DW-1:0] q0;
  logic [DW-1:0] q1;
  logic [DW-1:0] q2;
  logic [DW-1:0] q3;
  logic [1:0]    rd_ptr;
  logic          pop_ok;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, din,
    input  q0, q1, q2, q3, rd_ptr, pop_ok, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, din,
    output q0, q1, q2, q3, rd_ptr, pop_ok, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/fifo4_ctrl.sv
// 4-entry storage and pointer controller: holds entries, pointers, count and status/error flags.
// Read data is formed downstream by a 4:1 mux selected by rd_ptr and enabled by pop_ok.
module fifo4_ctrl #(
  parameter int unsigned DW = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo4_ctrl_if.slave        fifo
);

  logic [DW-1:0] q_q [4];
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q,  count_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;
  logic          pop_acc;
  logic          push_acc;

  // A push while full is only taken when a pop frees the head slot in the same cycle.
  always_comb begin
    pop_acc  = fifo.pop & (count_q != 3'd0);
    push_acc = fifo.push & ((count_q != 3'd4) | pop_acc);

    wr_ptr_d = push_acc ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + 2'd1 : rd_ptr_q;

    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == 3'd4);
    empty_d = (count_d == 3'd0);
    ovf_d   = fifo.push & ~push_acc;
    udf_d   = fifo.pop  & ~pop_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        q_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (push_acc) begin
        q_q[wr_ptr_q] <= fifo.din;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign fifo.q0        = q_q[0];
  assign fifo.q1        = q_q[1];
  assign fifo.q2        = q_q[2];
  assign fifo.q3        = q_q[3];
  assign fifo.rd_ptr    = rd_ptr_q;
  assign fifo.pop_ok    = pop_acc;
  assign fifo.count     = count_q;
  assign fifo.full      = full_q;
  assign fifo.empty     = empty_q;
  assign fifo.overflow  = ovf_q;
  assign fifo.underflow = udf_q;

endmodule

// File: tb/tb_fifo4_ctrl.sv
// Directed bench for fifo4_ctrl: stimulus queues expected pop data; a negedge monitor checks the mux output.
module tb_fifo4_ctrl;

  logic clk;
  logic rst;

  fifo4_ctrl_if #(.DW(16)) bus ();

  fifo4_ctrl #(.DW(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus)
  );

  int unsigned vectors;
  int unsigned miscompares;
  logic [15:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4:1 read mux as the consumer would build it.
  function automatic logic [15:0] mux_out();
    case (bus.rd_ptr)
      2'd0:    return bus.q0;
      2'd1:    return bus.q1;
      2'd2:    return bus.q2;
      default: return bus.q3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; leaves the bench at the following posedge+1.
  task automatic step(input logic p, input logic o, input logic [15:0] d,
                      input logic pok, input logic [15:0] pdata);
    bus.push = p;
    bus.pop  = o;
    bus.din  = d;
    if (pok) exp_q.push_back(pdata);
    #1;
    chk("pop_ok", {31'd0, bus.pop_ok}, {31'd0, pok});
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.pop_ok) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_data: unexpected pop of %0h at %0t", mux_out(), $time);
      end else begin
        chk("rd_data", {16'd0, mux_out()}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full",  {31'd0, bus.full},  32'd0);
    chk("rst_pop_ok", {31'd0, bus.pop_ok}, 32'd0);
    rst = 1'b0;

    // Fill and overflow
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'hA001 + 16'(i), 1'b0, 16'h0);
      chk("fill_count", {29'd0, bus.count}, 32'(i + 1));
    end
    chk("fill_q0", {16'd0, bus.q0}, 32'hA001);
    chk("fill_q1", {16'd0, bus.q1}, 32'hA002);
    chk("fill_q2", {16'd0, bus.q2}, 32'hA003);
    chk("fill_q3", {16'd0, bus.q3}, 32'hA004);
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    chk("fill_empty", {31'd0, bus.empty}, 32'd0);
    step(1'b1, 1'b0, 16'hA005, 1'b0, 16'h0);
    chk("ovf_pulse", {31'd0, bus.overflow}, 32'd1);
    chk("ovf_q0", {16'd0, bus.q0}, 32'hA001);
    chk("ovf_q3", {16'd0, bus.q3}, 32'hA004);
    chk("ovf_count", {29'd0, bus.count}, 32'd4);
    step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("ovf_clear", {31'd0, bus.overflow}, 32'd0);

    // Drain and underflow
    for (int i = 0; i < 4; i++) begin
      chk("drain_rd_ptr", {30'd0, bus.rd_ptr}, 32'(i));
      step(1'b0, 1'b1, 16'h0, 1'b1, 16'hA001 + 16'(i));
    end
    chk("drain_rd_ptr_wrap", {30'd0, bus.rd_ptr}, 32'd0);
    chk("drain_empty", {31'd0, bus.empty}, 32'd1);
    chk("drain_count", {29'd0, bus.count}, 32'd0);
    step(1'b0, 1'b1, 16'h0, 1'b0, 16'h0);
    chk("udf_pulse", {31'd0, bus.underflow}, 32'd1);
    chk("udf_rd_ptr", {30'd0, bus.rd_ptr}, 32'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("udf_clear", {31'd0, bus.underflow}, 32'd0);

    // Wrap-around: P P O P O P O P O P O O
    cnt = 0;
    begin
      int np;
      int nq;
      string pat;
      np  = 0;
      nq  = 0;
      pat = "PPOPOPOPOPOO";
      for (int i = 0; i < 12; i++) begin
        if (pat[i] == "P") begin
          step(1'b1, 1'b0, 16'hC001 + 16'(np), 1'b0, 16'h0);
          np++;
          cnt++;
        end else begin
          step(1'b0, 1'b1, 16'h0, 1'b1, 16'hC001 + 16'(nq));
          nq++;
          cnt--;
        end
        chk("wrap_count", {29'd0, bus.count}, 32'(cnt));
      end
    end
    chk("wrap_rd_ptr", {30'd0, bus.rd_ptr}, 32'd2);

    // Reach full with rd_ptr = 1: entries e0=D007 e1=D004 e2=D005 e3=D006
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'hD001 + 16'(i), 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0, 1'b1, 16'hD001 + 16'(i));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'hD005 + 16'(i), 1'b0, 16'h0);
    chk("sf_full", {31'd0, bus.full}, 32'd1);
    chk("sf_rd_ptr", {30'd0, bus.rd_ptr}, 32'd1);
    step(1'b1, 1'b1, 16'hBEEF, 1'b1, 16'hD004);
    chk("sf_q1", {16'd0, bus.q1}, 32'hBEEF);
    chk("sf_count", {29'd0, bus.count}, 32'd4);
    chk("sf_rd_ptr_next", {30'd0, bus.rd_ptr}, 32'd2);
    chk("sf_no_ovf", {31'd0, bus.overflow}, 32'd0);
    step(1'b0, 1'b1, 16'h0, 1'b1, 16'hD005);
    step(1'b0, 1'b1, 16'h0, 1'b1, 16'hD006);
    step(1'b0, 1'b1, 16'h0, 1'b1, 16'hD007);
    step(1'b0, 1'b1, 16'h0, 1'b1, 16'hBEEF);
    chk("sf_drain_empty", {31'd0, bus.empty}, 32'd1);

    // Asynchronous reset between edges with count = 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'hE001 + 16'(i), 1'b0, 16'h0);
    chk("pre_rst_count", {29'd0, bus.count}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_count", {29'd0, bus.count}, 32'd0);
    chk("arst_empty", {31'd0, bus.empty}, 32'd1);
    chk("arst_full", {31'd0, bus.full}, 32'd0);
    chk("arst_rd_ptr", {30'd0, bus.rd_ptr}, 32'd0);
    chk("arst_q", {bus.q0 | bus.q1, bus.q2 | bus.q3}, 32'd0);
    bus.push = 1'b1;
    bus.din  = 16'h5555;
    @(posedge clk);
    #1;
    chk("rst_ignores_push", {29'd0, bus.count}, 32'd0);
    bus.push = 1'b0;
    rst = 1'b0;

    // Simultaneous push/pop when empty
    step(1'b1, 1'b1, 16'h1234, 1'b0, 16'h0);
    chk("se_underflow", {31'd0, bus.underflow}, 32'd1);
    chk("se_count", {29'd0, bus.count}, 32'd1);
    chk("se_q0", {16'd0, bus.q0}, 32'h1234);
    step(1'b0, 1'b1, 16'h0, 1'b1, 16'h1234);
    chk("se_empty", {31'd0, bus.empty}, 32'd1);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo4_ctrl.md
# fifo4_ctrl

Storage and pointer controller for the 4-entry × 16-bit FIFO. It holds the four data registers and the write/read pointers, and produces the full/empty status and error flags. Its entry outputs, read pointer and gated pop drive the data, select and pop inputs of the downstream 4:1 read multiplexer. Read data is therefore combinational from this block's registers through the mux, valid during the cycle in which the pop is accepted.

## Interface
Parameters:
- DW, 16, data width of each entry
- None other; depth is fixed at 4, so pointers are 2 bits and the count is 3 bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- push  input  1  write request for din this cycle
- pop  input  1  read request this cycle
- din  input  DW  write data
- q0, q1, q2, q3  output  DW each  storage entries 0..3; feed mux data inputs a, b, c, d
- rd_ptr  output  2  read pointer; feeds mux select
- pop_ok  output  1  accepted pop; feeds mux pop enable
- count  output  3  number of occupied entries, 0..4
- full  output  1  count == 4
- empty  output  1  count == 0
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected

## Operation
- Reset (asynchronous, immediate on rst high):
  - q0..q3 = 0; wr_ptr = 0; rd_ptr = 0; count = 0.
  - empty = 1; full = 0; overflow = 0; underflow = 0.
  - pop_ok = 0 follows combinationally, because empty = 1.
- Acceptance (combinational):
  - pop_acc = pop & (count != 0).
  - push_acc = push & ((count != 4) | pop_acc). A push is accepted while full only if a pop is accepted in the same cycle.
  - pop_ok = pop_acc.
- Accepted push:
  - din is written to entry[wr_ptr] at the clock edge.
  - wr_ptr advances by 1 modulo 4 (3 wraps to 0).
- Accepted pop:
  - rd_ptr advances by 1 modulo 4 at the clock edge.
  - Entry contents are not cleared.
- Count update:
  - +1 on push_acc only; −1 on pop_acc only.
  - Unchanged when both or neither are accepted.
  - Count is never driven outside 0..4.
- Flags:
  - full and empty are registered and derived from the next count value, so they are consistent with count in every cycle.
- Error pulses (registered, asserted for exactly the cycle after the request):
  - overflow = push & ~push_acc.
  - underflow = pop & ~pop_acc.
- Simultaneous push and pop cases:
  - When empty: the push is accepted and the pop is rejected (underflow pulses). Data is not forwarded in the same cycle.
  - When full: both are accepted. Here wr_ptr == rd_ptr. The mux presents the old entry during the cycle and the new data overwrites that entry at the edge.
  - When 1 ≤ count ≤ 3: both are accepted and count is unchanged.
- Storage behaviour:
  - Only the selected entry is written; all other entries hold their value.
  - No state changes when no request is accepted.

## Timing
- Write latency: din is visible on q[wr_ptr] one cycle after the push edge. It is poppable from the next cycle if that entry is at the head.
- Read latency: zero. With pop high, the mux output equals q[rd_ptr] in the same cycle, and rd_ptr advances at the following edge.
- count, full, empty, rd_ptr and the error pulses all update on the same edge as the accepted or rejected request.
- rst asserted mid-operation:
  - All state clears immediately, regardless of the clock.
  - Requests present while rst is high are ignored.
  - After rst is released, the first edge operates from the empty state.
- Throughput: one push and one pop per cycle. Pointer wrap has no bubble.

## Test plan
- Reset: assert rst with count = 3 and q entries nonzero, between clock edges → count = 0, empty = 1, full = 0, rd_ptr = 0, q0..q3 = 0 immediately.
- Fill and overflow: push 16'hA001, A002, A003, A004 on consecutive cycles → q0..q3 hold those values, count = 4, full = 1. A fifth push of 16'hA005 → overflow pulses for one cycle and q0..q3 are unchanged.
- Drain and underflow:
  - From full, pop four times → pop_ok = 1 each cycle; rd_ptr steps 0,1,2,3,0; mux output is A001..A004 in order; empty = 1 after the fourth pop.
  - A fifth pop → pop_ok = 0, underflow pulses, rd_ptr stays 0.
- Wrap-around: push 6 and pop 6, interleaved as push, push, pop, push, pop, … → data order is preserved across the wr_ptr and rd_ptr wrap from 3 to 0, and count never exceeds 2.
- Simultaneous when full: with full = 1 and rd_ptr = 1, push 16'hBEEF with pop → same cycle mux output = old q1; next cycle q1 = BEEF, count = 4, rd_ptr = 2, no overflow.
- Simultaneous when empty: push 16'h1234 with pop → underflow pulses, count = 1, q0 = 1234; the next pop returns 1234.
